// File: rtl/dw_sqrt_share_ctrl.sv
// dw_sqrt_share_ctrl: round-robin shared iterative integer square root, one root bit per clock
// Ports: clk, rst_n (async active-low), req_valid/req_ready/req_data (per-requester request channels),
//        rsp_valid/rsp_ready/rsp_id/rsp_root (shared response channel), busy (CALC or DONE).
//        Define SQRT_SHARE_REM_EN to add rsp_rem = operand - root^2.
module dw_sqrt_share_ctrl #(
  parameter int WIDTH   = 32,
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int TC_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [WIDTH/2-1:0]    rsp_root,
`ifdef SQRT_SHARE_REM_EN
  output logic [WIDTH/2:0]      rsp_rem,
`endif
  output logic                  busy
);
  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(HW);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q;
  logic [ID_W-1:0] ptr_q, gnt_id, j;
  logic gnt_any, ge;
  logic [WIDTH-1:0] data_a [NREQ];
  logic [WIDTH-1:0] op_q, raw, op_in;
  logic [HW+1:0] rem_q, rem_sh, trial, rem_d;
  logic [HW-1:0] root_q, root_d;
  logic [CW-1:0] cnt_q;
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign data_a[g] = req_data[g*WIDTH +: WIDTH];
  end
  // first valid requester searching upward from the slot after the last winner
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    j = '0;
    for (int i = 1; i <= NREQ; i++) begin
      j = ID_W'((int'(ptr_q) + i) % NREQ);
      if (!gnt_any && req_valid[j]) begin
        gnt_any = 1'b1;
        gnt_id = j;
      end
    end
  end
  assign req_ready = (state_q == IDLE && gnt_any) ? NREQ'(1) << gnt_id : '0;
  assign busy = state_q != IDLE;
  assign raw = data_a[gnt_id];
  // magnitude of a negative two's-complement operand; the most negative value maps to 2^(WIDTH-1)
  assign op_in = (TC_MODE != 0 && raw[WIDTH-1]) ? -raw : raw;
  // restoring step: bring in the next operand bit pair, try subtracting {root,01}
  assign rem_sh = (rem_q << 2) | {{HW{1'b0}}, op_q[WIDTH-1 -: 2]};
  assign trial = {root_q, 2'b01};
  assign ge = rem_sh >= trial;
  assign rem_d = ge ? rem_sh - trial : rem_sh;
  assign root_d = {root_q[HW-2:0], ge};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= ID_W'(NREQ - 1);
      op_q <= '0;
      rem_q <= '0;
      root_q <= '0;
      cnt_q <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_root <= '0;
`ifdef SQRT_SHARE_REM_EN
      rsp_rem <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (gnt_any) begin
          ptr_q <= gnt_id;
          rsp_id <= gnt_id;
          op_q <= op_in;
          rem_q <= '0;
          root_q <= '0;
          cnt_q <= '0;
          state_q <= CALC;
        end
        CALC: begin
          op_q <= op_q << 2;
          rem_q <= rem_d;
          root_q <= root_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(HW - 1)) begin
            rsp_root <= root_d;
`ifdef SQRT_SHARE_REM_EN
            rsp_rem <= rem_d[HW:0];
`endif
            rsp_valid <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dw_sqrt_share_ctrl.sv
// tb_dw_sqrt_share_ctrl: directed bench for dw_sqrt_share_ctrl (unsigned and two's-complement instances)
module tb_dw_sqrt_share_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] v0 = '0, v1 = '0, r0, r1;
  logic [127:0] d0 = '0, d1 = '0;
  logic rr0 = 1'b1, rr1 = 1'b1, rv0, rv1, b0, b1;
  logic [1:0] id0, id1;
  logic [15:0] rt0, rt1;
`ifdef SQRT_SHARE_REM_EN
  logic [16:0] rm0, rm1;
`endif
  int errs = 0, checks = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dw_sqrt_share_ctrl #(.WIDTH(32), .NREQ(4), .ID_W(2), .TC_MODE(0)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(r0), .req_data(d0),
    .rsp_valid(rv0), .rsp_ready(rr0), .rsp_id(id0), .rsp_root(rt0),
`ifdef SQRT_SHARE_REM_EN
    .rsp_rem(rm0),
`endif
    .busy(b0));
  dw_sqrt_share_ctrl #(.WIDTH(32), .NREQ(4), .ID_W(2), .TC_MODE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(r1), .req_data(d1),
    .rsp_valid(rv1), .rsp_ready(rr1), .rsp_id(id1), .rsp_root(rt1),
`ifdef SQRT_SHARE_REM_EN
    .rsp_rem(rm1),
`endif
    .busy(b1));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // wait for a grant on u0, check it went to k, then advance past the grant edge
  task automatic grant0(input int k, input string tag);
    int n = 0;
    #1;
    while (r0 == 4'd0 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, 64'(r0), 64'(1) << k);
    step();
  endtask
  // called just after the grant edge: result must appear 16 edges later
  task automatic resp0(input int k, input logic [15:0] er, input string tag);
    int n = 0;
    while (!rv0 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd16);
    chk({tag, "_id"}, 64'(id0), 64'(k));
    chk({tag, "_root"}, 64'(rt0), 64'(er));
    chk({tag, "_busy"}, 64'(b0), 64'd1);
  endtask
  task automatic do_req0(input int k, input logic [31:0] a, input logic [15:0] er, input string tag);
    d0[k*32 +: 32] = a;
    v0[k] = 1'b1;
    grant0(k, tag);
    v0[k] = 1'b0;
    resp0(k, er, tag);
    step();
    chk({tag, "_vdrop"}, 64'(rv0), 64'd0);
    chk({tag, "_bdrop"}, 64'(b0), 64'd0);
  endtask
  task automatic do_req1(input int k, input logic [31:0] a, input logic [15:0] er, input logic [16:0] erem, input string tag);
    int n = 0;
    d1[k*32 +: 32] = a;
    v1[k] = 1'b1;
    #1;
    while (r1 == 4'd0 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, 64'(r1), 64'(1) << k);
    step();
    v1 = '0;
    n = 0;
    while (!rv1 && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd16);
    chk({tag, "_id"}, 64'(id1), 64'(k));
    chk({tag, "_root"}, 64'(rt1), 64'(er));
`ifdef SQRT_SHARE_REM_EN
    chk({tag, "_rem"}, 64'(rm1), 64'(erem));
`else
    n = int'(erem);
`endif
    step();
    chk({tag, "_vdrop"}, 64'(rv1), 64'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] rrx [4];
    logic seen;
    int tg, tprev;
    rrx = '{16'd10, 16'd1, 16'd1000, 16'd9};
    tprev = 0;
    #2;
    chk("rst_valid", 64'(rv0), 64'd0);
    chk("rst_id", 64'(id0), 64'd0);
    chk("rst_root", 64'(rt0), 64'd0);
    chk("rst_busy", 64'(b0), 64'd0);
    chk("rst_ready", 64'(r0), 64'd0);
    chk("rst_valid_tc", 64'(rv1), 64'd0);
    chk("rst_busy_tc", 64'(b1), 64'd0);
    step();
    rst_n = 1'b1;
    do_req0(0, 32'd144, 16'd12, "sq144");
    do_req0(1, 32'd0, 16'd0, "zero");
    do_req0(2, 32'd1, 16'd1, "one");
    do_req0(3, 32'hFFFF_FFFF, 16'd65535, "max");
    do_req0(0, 32'hFFFE_0001, 16'd65535, "sq65535");
    do_req0(1, 32'hFFFE_0000, 16'd65534, "sq65535m1");
    do_req0(2, 32'hFFFF_FF70, 16'd65535, "unsigned_neg");
    do_req0(3, 32'h8000_0000, 16'd46340, "unsigned_msb");
    // round robin from a fresh reset with all four requesters active
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    d0 = {32'd99, 32'd1000000, 32'd2, 32'd100};
    v0 = 4'hF;
    for (int i = 0; i < 8; i++) begin
      grant0(i % 4, "rr");
      tg = cyc;
      if (i > 0) chk("rr_gap", 64'(tg - tprev), 64'd18);
      tprev = tg;
      resp0(i % 4, rrx[i % 4], "rr");
      step();
    end
    v0 = '0;
    // backpressure: response held while others wait
    rr0 = 1'b0;
    d0[2*32 +: 32] = 32'd625;
    d0[3*32 +: 32] = 32'd49;
    v0[2] = 1'b1;
    grant0(2, "bp");
    v0 = 4'b1011;
    resp0(2, 16'd25, "bp");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", 64'(rv0), 64'd1);
      chk("bp_hold_root", 64'(rt0), 64'd25);
      chk("bp_hold_id", 64'(id0), 64'd2);
      chk("bp_hold_ready", 64'(r0), 64'd0);
    end
    rr0 = 1'b1;
    step();
    chk("bp_release_valid", 64'(rv0), 64'd0);
    chk("bp_next_ready", 64'(r0), 64'b1000);
    grant0(3, "bp_next");
    v0 = '0;
    resp0(3, 16'd7, "bp_next");
    step();
    // reset in the middle of CALC
    d0[1*32 +: 32] = 32'd10000;
    v0[1] = 1'b1;
    grant0(1, "abort");
    v0 = '0;
    for (int i = 0; i < 7; i++) step();
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(rv0), 64'd0);
    chk("abort_busy", 64'(b0), 64'd0);
    chk("abort_id", 64'(id0), 64'd0);
    chk("abort_root", 64'(rt0), 64'd0);
    step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      seen = seen | rv0;
    end
    chk("abort_no_rsp", 64'(seen), 64'd0);
    d0[0 +: 32] = 32'd10000;
    d0[32 +: 32] = 32'd81;
    v0 = 4'b0011;
    grant0(0, "after_abort");
    v0 = '0;
    resp0(0, 16'd100, "after_abort");
    step();
    // two's-complement instance
    do_req1(0, 32'h8000_0000, 16'd46340, 17'd88048, "tc_min");
    do_req1(1, 32'hFFFF_FFFF, 16'd1, 17'd0, "tc_m1");
    do_req1(2, 32'hFFFF_FF70, 16'd12, 17'd0, "tc_m144");
    do_req1(3, 32'd150, 16'd12, 17'd6, "tc_150");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
